imem_loader: RTL and testbench

- Run-time program loader and fetch-port arbiter for the 128-word single-cycle-read instruction memory of the pipelined ARM/LEGv8 core.
- While the CPU runs, the loader passes the CPU fetch address through to the memory read port.
- On command, it holds the CPU in reset, takes a byte stream (e.g. from a UART RX) over a valid/ready handshake, assembles 32-bit words, and writes them to the memory write port from word 0 upward.
- It then releases the CPU after a fixed hold period, so new programs load without resynthesis.

---
 rtl/imem_loader.sv | 198 +++++++++++++++++++
 tb/tb_imem_loader.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Run-time program loader and fetch-port arbiter for the instruction memory.
// Holds the core in reset while a byte stream is packed into words and written from word 0 upward.
module imem_loader #(
  parameter int N           = 32,
  parameter int ADDR_W      = 7,
  parameter int DEPTH       = 128,
  parameter int HOLD_CYCLES = 4,
  parameter int TIMEOUT     = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_start,
  input  logic [7:0]        ld_count,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [N-1:0]      mem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [7:0]        words_loaded
);

  localparam int BYTES = N / 8;
  localparam int BI_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int HC_W  = $clog2(HOLD_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [8:0] DEPTH_C = 9'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WRITE, S_HOLD, S_ERR} state_t;

  state_t            state_q, state_d;
  logic [BI_W-1:0]   byte_idx_q, byte_idx_d;
  logic [7:0]        word_idx_q, word_idx_d;
  logic [7:0]        count_q, count_d;
  logic [HC_W-1:0]   hold_q, hold_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              flag_q, flag_d;
  logic [N-1:0]      wbuf_q, wbuf_d;

  logic              cpu_reset_q, cpu_reset_d;
  logic              busy_q, busy_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_waddr_q, mem_waddr_d;
  logic [N-1:0]      mem_wdata_q, mem_wdata_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [7:0]        wl_q, wl_d;

  logic start_ok, last_byte, to_expire, last_word;

  assign start_ok  = (ld_count != 8'd0) && ({1'b0, ld_count} <= DEPTH_C);
  assign last_byte = (byte_idx_q == BI_W'(BYTES - 1));
  assign to_expire = (to_cnt_q == TO_W'(TIMEOUT - 1));
  assign last_word = ((word_idx_q + 8'd1) == count_q);

  // State and control registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_HOLD;
      hold_q      <= HC_W'(HOLD_CYCLES);
      flag_q      <= 1'b0;
      byte_idx_q  <= '0;
      word_idx_q  <= '0;
      count_q     <= '0;
      to_cnt_q    <= '0;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b1;
      mem_we_q    <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      wl_q        <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      flag_q      <= flag_d;
      byte_idx_q  <= byte_idx_d;
      word_idx_q  <= word_idx_d;
      count_q     <= count_d;
      to_cnt_q    <= to_cnt_d;
      cpu_reset_q <= cpu_reset_d;
      busy_q      <= busy_d;
      mem_we_q    <= mem_we_d;
      mem_waddr_q <= mem_waddr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      error_q     <= error_d;
      wl_q        <= wl_d;
    end
  end

  // Assembly buffer is pure data; every byte lane is rewritten before use
  always_ff @(posedge clk) begin
    wbuf_q <= wbuf_d;
  end

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    word_idx_d = word_idx_q;
    count_d    = count_q;
    hold_d     = hold_q;
    to_cnt_d   = to_cnt_q;
    flag_d     = flag_q;
    wbuf_d     = wbuf_q;
    unique case (state_q)
      S_IDLE, S_ERR: begin
        if (ld_start) begin
          if (start_ok) begin
            state_d    = S_LOAD;
            byte_idx_d = '0;
            word_idx_d = '0;
            count_d    = ld_count;
            to_cnt_d   = '0;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_LOAD: begin
        if (rx_valid) begin
          for (int k = 0; k < BYTES; k++) begin
            if (byte_idx_q == BI_W'(k)) wbuf_d[8*k +: 8] = rx_data;
          end
          to_cnt_d = '0;
          if (last_byte) begin
            byte_idx_d = '0;
            state_d    = S_WRITE;
          end else begin
            byte_idx_d = byte_idx_q + 1'b1;
          end
        end else if (to_expire) begin
          state_d = S_ERR;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      S_WRITE: begin
        word_idx_d = word_idx_q + 8'd1;
        if (last_word) begin
          state_d = S_HOLD;
          hold_d  = HC_W'(HOLD_CYCLES);
          flag_d  = 1'b1;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_HOLD: begin
        hold_d = hold_q - 1'b1;
        if (hold_q == HC_W'(1)) begin
          state_d = S_IDLE;
          flag_d  = 1'b0;
        end
      end
      default: state_d = S_HOLD;
    endcase
  end

  // Registered outputs are computed from the state being entered
  always_comb begin
    cpu_reset_d = (state_d != S_IDLE);
    busy_d      = (state_d == S_LOAD) || (state_d == S_WRITE) || (state_d == S_HOLD);
    error_d     = (state_d == S_ERR);
    mem_we_d    = (state_d == S_WRITE);
    mem_waddr_d = mem_waddr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = (state_q == S_HOLD) && (state_d == S_IDLE) && flag_q;
    wl_d        = wl_q;
    if ((state_q == S_LOAD) && (state_d == S_WRITE)) begin
      mem_waddr_d = word_idx_q[ADDR_W-1:0];
      mem_wdata_d = wbuf_d;
    end
    if (((state_q == S_IDLE) || (state_q == S_ERR)) && (state_d == S_LOAD)) begin
      wl_d = '0;
    end else if (state_q == S_WRITE) begin
      wl_d = word_idx_q + 8'd1;
    end
    rx_ready  = (state_q == S_LOAD);
    mem_raddr = (state_q == S_IDLE) ? cpu_addr : '0;
  end

  assign cpu_reset    = cpu_reset_q;
  assign busy         = busy_q;
  assign mem_we       = mem_we_q;
  assign mem_waddr    = mem_waddr_q;
  assign mem_wdata    = mem_wdata_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = wl_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: a behavioural model checked every cycle,
// a memory scoreboard checked per load, and literal expectations for the fixed scenarios.
module tb_imem_loader;
  localparam int N = 32, ADDR_W = 7, DEPTH = 128, HOLD = 4, TO = 16;

  logic              clk = 1'b0, reset = 1'b1, ld_start = 1'b0, rx_valid = 1'b0;
  logic [7:0]        ld_count = '0, rx_data = '0;
  logic [ADDR_W-1:0] cpu_addr = 7'h05;
  logic              rx_ready, mem_we, cpu_reset, busy, done, error;
  logic [ADDR_W-1:0] mem_raddr, mem_waddr;
  logic [N-1:0]      mem_wdata;
  logic [7:0]        words_loaded;

  imem_loader #(.N(N), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .ld_start(ld_start), .ld_count(ld_count),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .cpu_addr(cpu_addr),
    .mem_raddr(mem_raddr), .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int n_assert = 0, n_fail = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what the loader must present after each clock edge
  typedef enum int {M_IDLE, M_LOAD, M_WRITE, M_HOLD, M_ERR} mmode_t;
  mmode_t      mode = M_HOLD;
  logic [7:0]  m_q[$];
  int          m_words = 0, m_target = 0, m_hold = 0, m_idle = 0;
  bit          m_flag = 0, model_on = 0;
  bit          e_rst = 1, e_we = 0, e_done = 0, e_err = 0, e_busy = 1;
  int          e_waddr = 0, e_wl = 0;
  logic [31:0] e_wdata = '0;

  always @(posedge clk) begin
    if (reset) begin
      mode = M_HOLD; m_hold = HOLD; m_flag = 0; model_on = 1;
      e_we = 0; e_done = 0; e_waddr = 0; e_wdata = '0; e_wl = 0;
      m_q.delete();
    end else begin
      e_we = 0; e_done = 0;
      case (mode)
        M_IDLE, M_ERR: if (ld_start) begin
          if (ld_count >= 1 && int'(ld_count) <= DEPTH) begin
            mode = M_LOAD; m_target = ld_count; m_words = 0; e_wl = 0; m_idle = 0;
            m_q.delete();
          end else mode = M_ERR;
        end
        M_LOAD: if (rx_valid) begin
          m_q.push_back(rx_data);
          m_idle = 0;
          if (m_q.size() == N / 8) begin
            e_we = 1; e_waddr = m_words; e_wdata = '0;
            for (int k = 0; k < N / 8; k++) e_wdata[8*k +: 8] = m_q[k];
            m_q.delete();
            mode = M_WRITE;
          end
        end else begin
          m_idle++;
          if (m_idle == TO) mode = M_ERR;
        end
        M_WRITE: begin
          m_words++;
          e_wl = m_words;
          if (m_words == m_target) begin mode = M_HOLD; m_hold = HOLD; m_flag = 1; end
          else mode = M_LOAD;
        end
        M_HOLD: begin
          m_hold--;
          if (m_hold == 0) begin mode = M_IDLE; e_done = m_flag; m_flag = 0; end
        end
        default: ;
      endcase
    end
    e_rst  = (mode != M_IDLE);
    e_err  = (mode == M_ERR);
    e_busy = (mode == M_LOAD) || (mode == M_WRITE) || (mode == M_HOLD);
  end

  // Per-cycle compare plus write/done monitor
  logic [38:0] wq[$];
  logic [31:0] sb[DEPTH];
  int cyc = 0, done_cnt = 0, last_we_cyc = 0, done_cyc = 0;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (model_on) begin
      chk("cpu_reset", cpu_reset, e_rst);
      chk("mem_we", mem_we, e_we);
      chk("mem_waddr", mem_waddr, e_waddr[ADDR_W-1:0]);
      chk("mem_wdata", mem_wdata, e_wdata);
      chk("done", done, e_done);
      chk("error", error, e_err);
      chk("busy", busy, e_busy);
      chk("words_loaded", words_loaded, e_wl[7:0]);
      chk("rx_ready", rx_ready, mode == M_LOAD);
      chk("mem_raddr", mem_raddr, (mode == M_IDLE) ? cpu_addr : 7'd0);
      if (mem_we) begin
        wq.push_back({mem_waddr, mem_wdata});
        sb[mem_waddr] = mem_wdata;
        last_we_cyc = cyc;
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
    end
  end

  bit rand_addr = 0;
  task automatic tick();
    @(posedge clk); #1;
    if (rand_addr) cpu_addr = 7'($urandom);
  endtask

  task automatic start(input int cnt);
    ld_count = 8'(cnt); ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
  endtask

  logic [7:0] stream[$];
  task automatic make_prog(input int words);
    stream.delete();
    for (int i = 0; i < words * 4; i++) stream.push_back(8'($urandom));
  endtask

  task automatic feed(input int gap_pct, input bit noise, input int max_bytes, output int sent);
    int i, budget;
    bit v, rdy;
    i = 0; budget = 0;
    while (i < stream.size() && i < max_bytes && budget < 5000) begin
      v = ($urandom_range(99) >= gap_pct);
      rx_valid = v;
      rx_data  = v ? stream[i] : 8'($urandom);
      if (noise && $urandom_range(9) == 0) begin ld_start = 1'b1; ld_count = 8'($urandom); end
      rdy = rx_ready;
      tick();
      ld_start = 1'b0;
      budget++;
      if (v && rdy) i++;
    end
    rx_valid = 1'b0;
    sent = i;
    if (budget >= 5000) chk("feed_budget", budget, 0);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 2000) begin tick(); k++; end
    if (k >= 2000) chk("wait_idle_budget", k, 0);
    tick();
  endtask

  task automatic check_mem(input int words);
    logic [31:0] w;
    chk("write_count", wq.size(), words);
    for (int i = 0; i < words; i++) begin
      w = {stream[4*i+3], stream[4*i+2], stream[4*i+1], stream[4*i]};
      chk("mem_word", sb[i], w);
    end
  endtask

  task automatic fixed_stream();
    stream.delete();
    stream.push_back(8'he4); stream.push_back(8'h03); stream.push_back(8'h01); stream.push_back(8'h8b);
    stream.push_back(8'hff); stream.push_back(8'h03); stream.push_back(8'h1f); stream.push_back(8'h8b);
  endtask

  initial begin
    int hi, s, k, dc, cnt;
    // Reset release with a fixed fetch address
    repeat (3) tick();
    reset = 1'b0;
    hi = 0;
    while (cpu_reset && hi < 20) begin hi++; tick(); end
    chk("reset_hold_cycles", hi, 4);
    chk("raddr_passthrough", mem_raddr, 7'h05);
    tick();
    chk("no_done_after_reset", done_cnt, 0);

    // Two-word fixed program, back-to-back bytes
    wq.delete(); done_cnt = 0;
    fixed_stream();
    start(2);
    feed(0, 0, 1000, s);
    wait_idle();
    chk("t2_writes", wq.size(), 2);
    chk("t2_word0", wq[0], {7'd0, 32'h8b0103e4});
    chk("t2_word1", wq[1], {7'd1, 32'h8b1f03ff});
    chk("t2_words_loaded", words_loaded, 8'd2);
    chk("t2_done_count", done_cnt, 1);
    chk("t2_done_delay", done_cyc - last_we_cyc, 5);

    // Same program with gaps and rx_valid held through WRITE cycles
    wq.delete();
    rand_addr = 1;
    start(2);
    feed(40, 0, 1000, s);
    wait_idle();
    chk("t3_writes", wq.size(), 2);
    chk("t3_word0", wq[0], {7'd0, 32'h8b0103e4});
    chk("t3_word1", wq[1], {7'd1, 32'h8b1f03ff});

    // Timeout on a partial word, then recovery
    wq.delete();
    make_prog(1);
    start(1);
    feed(0, 0, 3, s);
    k = 0;
    while (!error && k < 40) begin tick(); k++; end
    chk("t4_timeout_cycles", k, 16);
    chk("t4_error", error, 1'b1);
    chk("t4_cpu_reset", cpu_reset, 1'b1);
    chk("t4_no_write", wq.size(), 0);
    start(1);
    chk("t4_error_cleared", error, 1'b0);
    feed(20, 0, 1000, s);
    wait_idle();
    check_mem(1);

    // Invalid counts and ignored mid-load ld_start
    start(0);
    chk("t5_count0_err", error, 1'b1);
    wq.delete();
    make_prog(3);
    start(3);
    feed(30, 1, 1000, s);
    wait_idle();
    check_mem(3);
    chk("t5_words_loaded", words_loaded, 8'd3);
    start(129);
    chk("t5_count129_err", error, 1'b1);

    // Full-depth load
    wq.delete();
    make_prog(128);
    start(128);
    feed(10, 0, 1000, s);
    wait_idle();
    check_mem(128);
    chk("t6_last_addr", wq[wq.size()-1][38:32], 7'd127);
    chk("t6_words_loaded", words_loaded, 8'd128);

    // Reset in the middle of a load
    dc = done_cnt;
    make_prog(3);
    start(3);
    feed(0, 0, 5, s);
    reset = 1'b1;
    tick();
    chk("t6_we_after_reset", mem_we, 1'b0);
    reset = 1'b0;
    hi = 0;
    while (cpu_reset && hi < 20) begin hi++; tick(); end
    chk("t6_reset_hold", hi, 4);
    tick();
    chk("t6_no_done", done_cnt, dc);

    // Random loads
    for (int r = 0; r < 6; r++) begin
      wq.delete();
      cnt = $urandom_range(6, 1);
      make_prog(cnt);
      start(cnt);
      feed($urandom_range(50), 1, 1000, s);
      wait_idle();
      check_mem(cnt);
      repeat ($urandom_range(5)) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
